// File: rtl/xem7320_adc_ctrl.sv
// XEM7320 ADC capture / DAC control core: encode clock, triggered sample buffer with
// host pipe-out readback, and a 16-bit SPI configuration master for the DAC.
module xem7320_adc_ctrl #(
    parameter int DEPTH   = 2048,
    parameter int ENC_DIV = 5,
    parameter int SPI_DIV = 4
) (
    input  logic        sys_clk,
    input  logic        reset,
    input  logic [31:0] sample_count,
    input  logic [15:0] spi_word,
    input  logic        trig_acquire,
    input  logic        trig_spi,
    input  logic        adc_sample_vld,
    input  logic [11:0] adc_sample,
    output logic        adc_encode,
    input  logic        pipe_rd_en,
    output logic [31:0] pipe_dout,
    output logic [11:0] dac_data,
    output logic        dac_clk,
    output logic        dac_reset_pinmd,
    output logic        dac_sclk,
    output logic        dac_sdio,
    output logic        dac_cs_n,
    output logic [7:0]  led
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = $clog2(ENC_DIV + 1);
    localparam int SW = $clog2(SPI_DIV + 1);
    localparam logic [AW:0]   LEN_MAX = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] RD_LAST = AW'(DEPTH - 1);

    typedef enum logic [1:0] {CAP_IDLE, CAP_RUN, CAP_DONE} cap_state_t;
    typedef enum logic [1:0] {SPI_IDLE, SPI_LOW, SPI_HIGH, SPI_TAIL} spi_state_t;

    // ---------------- encode clock ----------------
    logic [EW-1:0] enc_cnt_q;
    logic          enc_q;
    logic          rdy_q;

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            enc_cnt_q <= '0;
            enc_q     <= 1'b0;
            rdy_q     <= 1'b0;
        end else begin
            enc_cnt_q <= (enc_cnt_q == EW'(ENC_DIV - 1)) ? '0 : enc_cnt_q + 1'b1;
            enc_q     <= (enc_cnt_q < EW'(ENC_DIV / 2));
            rdy_q     <= 1'b1;
        end
    end

    // ---------------- capture buffer ----------------
    cap_state_t    cap_q, cap_d;
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   len_q, len_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [32:0]   len_sum;
    logic [AW:0]   len_trig;
    logic          we;
    logic          rd_hit;
    logic [11:0]   mem [DEPTH];
    logic [31:0]   pipe_dout_q;
    logic [11:0]   dac_data_q;

    // sample_count + 4 is formed in 33 bits so a near-max count still clamps to DEPTH
    assign len_sum  = {1'b0, sample_count} + 33'd4;
    assign len_trig = (len_sum >= 33'(DEPTH)) ? LEN_MAX : len_sum[AW:0];
    assign rd_hit   = ({1'b0, rd_ptr_q} < wr_ptr_q);

    always_comb begin
        cap_d    = cap_q;
        wr_ptr_d = wr_ptr_q;
        len_d    = len_q;
        rd_ptr_d = rd_ptr_q;
        we       = 1'b0;
        if (pipe_rd_en && rd_ptr_q != RD_LAST)
            rd_ptr_d = rd_ptr_q + 1'b1;
        if (trig_acquire) begin
            cap_d    = CAP_RUN;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            len_d    = len_trig;
        end else if (cap_q == CAP_RUN && adc_sample_vld) begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (wr_ptr_q + 1'b1 == len_q)
                cap_d = CAP_DONE;
        end
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            cap_q       <= CAP_IDLE;
            wr_ptr_q    <= '0;
            len_q       <= '0;
            rd_ptr_q    <= '0;
            pipe_dout_q <= '0;
            dac_data_q  <= '0;
        end else begin
            cap_q    <= cap_d;
            wr_ptr_q <= wr_ptr_d;
            len_q    <= len_d;
            rd_ptr_q <= rd_ptr_d;
            if (pipe_rd_en)
                pipe_dout_q <= rd_hit ? {20'h0, mem[rd_ptr_q]} : '0;
            if (adc_sample_vld)
                dac_data_q <= adc_sample;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (we)
            mem[wr_ptr_q[AW-1:0]] <= adc_sample;
    end

    // ---------------- DAC SPI master ----------------
    spi_state_t    spi_q, spi_d;
    logic [SW-1:0] div_q, div_d;
    logic [3:0]    bit_q, bit_d;
    logic [15:0]   sh_q, sh_d;
    logic          sclk_q, sclk_d;
    logic          sdio_q, sdio_d;
    logic          csn_q, csn_d;
    logic          div_end;

    assign div_end = (div_q == SW'(SPI_DIV - 1));

    always_comb begin
        spi_d  = spi_q;
        div_d  = div_end ? '0 : div_q + 1'b1;
        bit_d  = bit_q;
        sh_d   = sh_q;
        sclk_d = sclk_q;
        sdio_d = sdio_q;
        csn_d  = csn_q;
        unique case (spi_q)
            SPI_IDLE: begin
                div_d = '0;
                if (trig_spi) begin
                    sh_d   = spi_word;
                    sdio_d = spi_word[15];
                    csn_d  = 1'b0;
                    bit_d  = '0;
                    spi_d  = SPI_LOW;
                end
            end
            SPI_LOW: begin
                if (div_end) begin
                    sclk_d = 1'b1;
                    spi_d  = SPI_HIGH;
                end
            end
            SPI_HIGH: begin
                // Falling edge: advance to the next bit, or close out after the 16th
                if (div_end) begin
                    sclk_d = 1'b0;
                    if (bit_q == 4'd15) begin
                        spi_d = SPI_TAIL;
                    end else begin
                        bit_d  = bit_q + 1'b1;
                        sh_d   = {sh_q[14:0], 1'b0};
                        sdio_d = sh_q[14];
                        spi_d  = SPI_LOW;
                    end
                end
            end
            SPI_TAIL: begin
                if (div_end) begin
                    csn_d  = 1'b1;
                    sdio_d = 1'b0;
                    spi_d  = SPI_IDLE;
                end
            end
            default: spi_d = SPI_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            spi_q  <= SPI_IDLE;
            div_q  <= '0;
            bit_q  <= '0;
            sh_q   <= '0;
            sclk_q <= 1'b0;
            sdio_q <= 1'b0;
            csn_q  <= 1'b1;
        end else begin
            spi_q  <= spi_d;
            div_q  <= div_d;
            bit_q  <= bit_d;
            sh_q   <= sh_d;
            sclk_q <= sclk_d;
            sdio_q <= sdio_d;
            csn_q  <= csn_d;
        end
    end

    // ---------------- outputs ----------------
    assign adc_encode      = enc_q;
    assign dac_clk         = enc_q;
    assign pipe_dout       = pipe_dout_q;
    assign dac_data        = dac_data_q;
    assign dac_reset_pinmd = 1'b0;
    assign dac_sclk        = sclk_q;
    assign dac_sdio        = sdio_q;
    assign dac_cs_n        = csn_q;
    assign led             = {1'b0, rdy_q, 3'b000, (spi_q != SPI_IDLE),
                              (cap_q == CAP_DONE), (cap_q == CAP_RUN)};

endmodule

// File: tb/tb_xem7320_adc_ctrl.sv
// Directed testbench for xem7320_adc_ctrl: encode clock, SPI framing, capture and pipe readback.
module tb_xem7320_adc_ctrl;

    logic        sys_clk = 1'b0;
    logic        reset;
    logic [31:0] sample_count;
    logic [15:0] spi_word;
    logic        trig_acquire;
    logic        trig_spi;
    logic        adc_sample_vld;
    logic [11:0] adc_sample;
    logic        adc_encode;
    logic        pipe_rd_en;
    logic [31:0] pipe_dout;
    logic [11:0] dac_data;
    logic        dac_clk;
    logic        dac_reset_pinmd;
    logic        dac_sclk;
    logic        dac_sdio;
    logic        dac_cs_n;
    logic [7:0]  led;

    int n_chk = 0;
    int n_bad = 0;

    xem7320_adc_ctrl #(.DEPTH(2048), .ENC_DIV(5), .SPI_DIV(4)) dut (
        .sys_clk(sys_clk), .reset(reset), .sample_count(sample_count), .spi_word(spi_word),
        .trig_acquire(trig_acquire), .trig_spi(trig_spi), .adc_sample_vld(adc_sample_vld),
        .adc_sample(adc_sample), .adc_encode(adc_encode), .pipe_rd_en(pipe_rd_en),
        .pipe_dout(pipe_dout), .dac_data(dac_data), .dac_clk(dac_clk),
        .dac_reset_pinmd(dac_reset_pinmd), .dac_sclk(dac_sclk), .dac_sdio(dac_sdio),
        .dac_cs_n(dac_cs_n), .led(led)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Runs one SPI frame; optionally fires a second trigger mid-transfer that must be ignored.
    task automatic spi_frame(input logic [15:0] word, input bit inject);
        logic [15:0] bits = '0;
        int          pulses = 0;
        bit          frame_ok = 1'b1;
        bit          done = 1'b0;
        logic        prev;
        spi_word = word;
        trig_spi = 1'b1;
        tick();
        trig_spi = 1'b0;
        chk("spi_cs_assert", {31'b0, dac_cs_n}, 32'd0);
        chk("spi_busy_led", {31'b0, led[2]}, 32'd1);
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            prev = dac_sclk;
            if (inject && cyc == 20) begin
                trig_spi = 1'b1;
                spi_word = 16'hFFFF;
            end else begin
                trig_spi = 1'b0;
            end
            tick();
            if (!prev && dac_sclk) begin
                bits = {bits[14:0], dac_sdio};
                pulses++;
                if (dac_cs_n !== 1'b0) frame_ok = 1'b0;
            end
            if (dac_cs_n === 1'b1) done = 1'b1;
        end
        trig_spi = 1'b0;
        chk("spi_done", {31'b0, done}, 32'd1);
        chk("spi_pulses", pulses, 32'd16);
        chk("spi_bits", {16'b0, bits}, {16'b0, word});
        chk("spi_frame", {31'b0, frame_ok}, 32'd1);
        chk("spi_sclk_idle", {31'b0, dac_sclk}, 32'd0);
        chk("spi_led_idle", {31'b0, led[2]}, 32'd0);
        for (int i = 0; i < 12; i++) tick();
        chk("spi_cs_stays_high", {31'b0, dac_cs_n}, 32'd1);
    endtask

    initial begin
        logic [11:0] vec [6];
        logic [31:0] rexp [6];
        logic        prev;
        bit          found;

        reset = 1'b1; sample_count = '0; spi_word = '0; trig_acquire = 1'b0; trig_spi = 1'b0;
        adc_sample_vld = 1'b0; adc_sample = '0; pipe_rd_en = 1'b0;
        repeat (3) tick();
        chk("rst_led", {24'b0, led}, 32'h0);
        chk("rst_cs_n", {31'b0, dac_cs_n}, 32'd1);
        chk("rst_encode", {31'b0, adc_encode}, 32'd0);
        chk("rst_pipe", pipe_dout, 32'h0);
        chk("rst_sclk", {31'b0, dac_sclk}, 32'd0);
        chk("rst_pinmd", {31'b0, dac_reset_pinmd}, 32'd0);

        reset = 1'b0;
        tick(); tick();
        chk("idle_led", {24'b0, led}, 32'h40);

        // Encode clock: find a rising edge, then expect high 2 / low 3 repeating
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            prev = adc_encode;
            tick();
            if (!prev && adc_encode) found = 1'b1;
        end
        chk("enc_rise_found", {31'b0, found}, 32'd1);
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk("enc_wave", {31'b0, adc_encode}, {31'b0, ((k % 5) < 2)});
            chk("dac_clk_wave", {31'b0, dac_clk}, {31'b0, ((k % 5) < 2)});
        end

        spi_frame(16'h0580, 1'b0);
        spi_frame(16'hA35C, 1'b1);

        // Full-depth capture: sample_count=2044 -> L=2048
        sample_count = 32'd2044;
        trig_acquire = 1'b1;
        tick();
        trig_acquire = 1'b0;
        chk("cap_busy_led", {24'b0, led}, 32'h41);
        for (int i = 0; i < 2048; i++) begin
            adc_sample = 12'(i);
            adc_sample_vld = 1'b1;
            tick();
            if (i == 2046) chk("cap_not_done_early", {31'b0, led[1]}, 32'd0);
        end
        adc_sample_vld = 1'b0;
        chk("cap_done_led", {24'b0, led}, 32'h42);
        chk("cap_dac_data", {20'b0, dac_data}, 32'd2047);
        for (int i = 0; i < 2048; i++) begin
            pipe_rd_en = 1'b1;
            tick();
            chk("rd_ramp", pipe_dout, 32'(i));
        end
        pipe_rd_en = 1'b0;
        tick();

        // Re-trigger after DONE with L=4; negative sample, then reads past L return zero
        vec[0] = 12'hE00; vec[1] = 12'h123; vec[2] = 12'h7FF; vec[3] = 12'h800;
        rexp[0] = 32'h0000_0E00; rexp[1] = 32'h0000_0123; rexp[2] = 32'h0000_07FF;
        rexp[3] = 32'h0000_0800; rexp[4] = 32'h0; rexp[5] = 32'h0;
        sample_count = 32'd0;
        trig_acquire = 1'b1;
        tick();
        trig_acquire = 1'b0;
        chk("recap_led", {24'b0, led}, 32'h41);
        for (int i = 0; i < 4; i++) begin
            adc_sample = vec[i];
            adc_sample_vld = 1'b1;
            tick();
            chk("dac_data_follow", {20'b0, dac_data}, {20'b0, vec[i]});
        end
        adc_sample_vld = 1'b0;
        chk("recap_done_led", {24'b0, led}, 32'h42);
        for (int i = 0; i < 6; i++) begin
            pipe_rd_en = 1'b1;
            tick();
            chk("rd_recap", pipe_dout, rexp[i]);
        end
        pipe_rd_en = 1'b0;

        // Simultaneous triggers are both honoured; then reset aborts the SPI frame
        sample_count = 32'hFFFF_FFFF;
        spi_word = 16'h1234;
        trig_acquire = 1'b1;
        trig_spi = 1'b1;
        tick();
        trig_acquire = 1'b0;
        trig_spi = 1'b0;
        chk("both_trig_led", {24'b0, led}, 32'h45);
        repeat (20) tick();
        chk("mid_cs_low", {31'b0, dac_cs_n}, 32'd0);
        reset = 1'b1;
        #1;
        chk("abort_cs_n", {31'b0, dac_cs_n}, 32'd1);
        chk("abort_sclk", {31'b0, dac_sclk}, 32'd0);
        chk("abort_led", {24'b0, led}, 32'h0);
        chk("abort_pipe", pipe_dout, 32'h0);
        tick();
        reset = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
